// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage; owns the PC, talks to a variable-latency
// instruction memory and writes the IF/ID register (all-zero instruction = bubble).
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   stall, branch, Jump               hazard stall and decode-stage redirects
//   branchAddr, jumpAddr              redirect targets from decode
//   imem_req/addr/ready/rdata         instruction-memory handshake
//   IF_ID_instr, IF_ID_PCout          IF/ID pipeline register (instr, its addr + 4)
//   pc                                current fetch PC
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        Jump,
  input  logic [31:0] branchAddr,
  input  logic [31:0] jumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PCout,
  output logic [31:0] pc
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  state_e      state_q;
  logic [31:0] pc_q, redir_pc_q, hold_instr_q, instr_q, pcout_q;
  logic        hold_valid_q;
  logic        redir, avail, unused_jump_hi;
  logic [31:0] target, pc_inc, fetch_data;
  // A filled hold buffer already owns the next instruction, so no new request is issued.
  assign imem_req       = (state_q == FETCH && !hold_valid_q) || state_q == DRAIN;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign IF_ID_instr    = instr_q;
  assign IF_ID_PCout    = pcout_q;
  assign redir          = (branch | Jump) & ~stall;
  assign target         = branch ? branchAddr : {pcout_q[31:28], jumpAddr[27:0]};
  assign avail          = hold_valid_q | (imem_req & imem_ready & (state_q == FETCH));
  assign pc_inc         = pc_q + 32'd4;
  assign fetch_data     = hold_valid_q ? hold_instr_q : imem_rdata;
  assign unused_jump_hi = ^jumpAddr[31:28];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'd0;
      instr_q      <= 32'd0;
      pcout_q      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (stall) begin
            if (imem_ready && !hold_valid_q) begin
              hold_valid_q <= 1'b1;
              hold_instr_q <= imem_rdata;
            end
          end else if (redir) begin
            instr_q <= 32'd0;
            pcout_q <= 32'd0;
            // The in-flight request can only be abandoned once memory has answered it.
            if (imem_ready || hold_valid_q) begin
              pc_q         <= target;
              hold_valid_q <= 1'b0;
            end else begin
              redir_pc_q <= target;
              state_q    <= DRAIN;
            end
          end else if (avail) begin
            instr_q      <= fetch_data;
            pcout_q      <= pc_inc;
            pc_q         <= pc_inc;
            hold_valid_q <= 1'b0;
          end else begin
            instr_q <= 32'd0;
            pcout_q <= 32'd0;
          end
        end
        DRAIN: begin
          instr_q <= 32'd0;
          pcout_q <= 32'd0;
          if (redir) redir_pc_q <= target;
          if (imem_ready) begin
            pc_q    <= redir ? target : redir_pc_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a wait-state memory model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, branch, jump;
  logic [31:0] branch_addr, jump_addr;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata, instr, pcout, pc;
  int          wait_n, cnt, errors, checks;

  if_stage dut (
    .clk(clk), .rst(rst_n), .stall(stall), .branch(branch), .Jump(jump),
    .branchAddr(branch_addr), .jumpAddr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .IF_ID_instr(instr), .IF_ID_PCout(pcout), .pc(pc)
  );

  always #5 clk = ~clk;

  assign imem_ready = imem_req && (cnt >= wait_n);
  assign imem_rdata = imem_addr | 32'h2000_0000;
  always @(posedge clk) cnt <= (imem_req && !imem_ready) ? cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, "_instr"}, instr, ei);
    chk({tag, "_pcout"}, pcout, ep);
  endtask

  initial begin
    errors = 0; checks = 0; cnt = 0; wait_n = 0;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    branch_addr = 32'd0; jump_addr = 32'd0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    ifid("rst_ifid", 32'd0, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("start_addr", imem_addr, 32'd0);
    chk("start_req", {31'd0, imem_req}, 32'd1);
    ifid("start_ifid", 32'd0, 32'd0);
    step();
    ifid("seq0", 32'h2000_0000, 32'd4);
    chk("seq_addr4", imem_addr, 32'd4);
    step();
    ifid("seq1", 32'h2000_0004, 32'd8);
    chk("seq_addr8", imem_addr, 32'd8);
    stall = 1'b1;
    chk("stall_req_first", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      ifid("stall_hold", 32'h2000_0004, 32'd8);
      chk("stall_pc", pc, 32'd8);
      chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    ifid("stall_release", 32'h2000_0008, 32'd12);
    chk("release_addr", imem_addr, 32'd12);
    step();
    ifid("no_dup", 32'h2000_000C, 32'd16);
    branch = 1'b1; branch_addr = 32'h40;
    step();
    branch = 1'b0;
    ifid("br_bubble", 32'd0, 32'd0);
    chk("br_addr", imem_addr, 32'h40);
    step();
    ifid("br_target", 32'h2000_0040, 32'h44);
    branch = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    ifid("wrap", 32'hFFFF_FFFC, 32'd0);
    chk("wrap_pc", pc, 32'd0);
    branch = 1'b1; branch_addr = 32'h1000_0004;
    step();
    branch = 1'b0;
    step();
    ifid("pre_jump", 32'h3000_0004, 32'h1000_0008);
    wait_n = 3;
    jump = 1'b1; jump_addr = 32'h0000_0100;
    step();
    jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_addr", imem_addr, 32'h1000_0008);
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      ifid("drain_ifid", 32'd0, 32'd0);
      step();
    end
    chk("jump_addr", imem_addr, 32'h1000_0100);
    ifid("jump_ifid", 32'd0, 32'd0);
    wait_n = 4;
    for (int i = 0; i < 4; i++) begin
      step();
      ifid("wait_bubble", 32'd0, 32'd0);
      chk("wait_pc", pc, 32'h1000_0100);
    end
    step();
    ifid("wait_done", 32'h3000_0100, 32'h1000_0104);
    branch = 1'b1; branch_addr = 32'h80;
    step();
    branch = 1'b0;
    chk("drain2_addr", imem_addr, 32'h1000_0104);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'd0);
    ifid("arst_ifid", 32'd0, 32'd0);
    wait_n = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("restart_addr", imem_addr, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    step();
    ifid("restart_ifid", 32'h2000_0000, 32'd4);
    chk("restart_pc", pc, 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
